// File: rtl/bip_cpu_hs.sv
// bip_cpu_hs: single-accumulator CPU. It executes one instruction per cycle
// from a program ROM with combinational read. Data-RAM accesses use a req/ack
// handshake that tolerates any number of wait states.
//
// Ports:
//   i_clock, i_reset       clock (rising edge), asynchronous active-low reset
//   i_rom_data             instruction at o_rom_addr, valid in the same cycle
//   i_ram_data, i_ram_ack  RAM read data and completion strobe
//   o_rom_addr             program counter
//   o_ram_addr/o_ram_data  registered RAM address and write data
//   o_ram_wr_enable        1 = write, 0 = read (only meaningful with o_ram_req)
//   o_ram_req              RAM request, held until an ack is sampled
//   o_acc                  accumulator
//   o_program_done         high in HALT
//   o_illegal              one-cycle pulse after an undefined opcode executes
//   o_cycle_count          saturating count of cycles spent outside HALT
//
// Handshake: o_ram_req rises on the edge that leaves EXEC for MEM. From then
// on, o_ram_req, o_ram_addr, o_ram_data and o_ram_wr_enable stay stable until
// i_ram_ack=1 is sampled on a rising edge. That edge completes the transfer.
// An ack on the first MEM edge is legal (zero wait states). An ack seen
// outside MEM is ignored.
module bip_cpu_hs #(
    parameter int NB_INSTRUCTION = 16,
    parameter int NB_OPCODE      = 5,
    parameter int NB_OPERAND     = NB_INSTRUCTION - NB_OPCODE,
    parameter int NB_ADDR        = 11,
    parameter int NB_DATA        = 16,
    parameter int NB_CYCLES      = 32
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_INSTRUCTION-1:0] i_rom_data,
    input  logic [NB_DATA-1:0]        i_ram_data,
    input  logic                      i_ram_ack,
    output logic [NB_ADDR-1:0]        o_rom_addr,
    output logic [NB_ADDR-1:0]        o_ram_addr,
    output logic [NB_DATA-1:0]        o_ram_data,
    output logic                      o_ram_wr_enable,
    output logic                      o_ram_req,
    output logic [NB_DATA-1:0]        o_acc,
    output logic                      o_program_done,
    output logic                      o_illegal,
    output logic [NB_CYCLES-1:0]      o_cycle_count
);

    typedef enum logic [1:0] {
        ST_EXEC = 2'd0,
        ST_MEM  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [NB_OPCODE-1:0] OP_HLT  = NB_OPCODE'(5'b00000);
    localparam logic [NB_OPCODE-1:0] OP_STO  = NB_OPCODE'(5'b00001);
    localparam logic [NB_OPCODE-1:0] OP_LD   = NB_OPCODE'(5'b00010);
    localparam logic [NB_OPCODE-1:0] OP_LDI  = NB_OPCODE'(5'b00011);
    localparam logic [NB_OPCODE-1:0] OP_ADD  = NB_OPCODE'(5'b00100);
    localparam logic [NB_OPCODE-1:0] OP_ADDI = NB_OPCODE'(5'b00101);
    localparam logic [NB_OPCODE-1:0] OP_SUB  = NB_OPCODE'(5'b00110);
    localparam logic [NB_OPCODE-1:0] OP_SUBI = NB_OPCODE'(5'b00111);
    localparam logic [NB_OPCODE-1:0] OP_AND  = NB_OPCODE'(5'b01000);
    localparam logic [NB_OPCODE-1:0] OP_ANDI = NB_OPCODE'(5'b01001);
    localparam logic [NB_OPCODE-1:0] OP_OR   = NB_OPCODE'(5'b01010);
    localparam logic [NB_OPCODE-1:0] OP_XOR  = NB_OPCODE'(5'b01100);
    localparam logic [NB_OPCODE-1:0] OP_JMP  = NB_OPCODE'(5'b01110);
    localparam logic [NB_OPCODE-1:0] OP_BEQ  = NB_OPCODE'(5'b01111);
    localparam logic [NB_OPCODE-1:0] OP_BNE  = NB_OPCODE'(5'b10000);
    localparam logic [NB_OPCODE-1:0] OP_BLT  = NB_OPCODE'(5'b10001);
    localparam logic [NB_OPCODE-1:0] OP_NOP  = NB_OPCODE'(5'b11111);

    state_t                 state_q, state_d;
    logic [NB_ADDR-1:0]     pc_q, pc_d;
    logic [NB_DATA-1:0]     acc_q, acc_d;
    logic [NB_OPCODE-1:0]   op_q, op_d;
    logic [NB_ADDR-1:0]     ram_addr_q, ram_addr_d;
    logic [NB_DATA-1:0]     ram_data_q, ram_data_d;
    logic                   ram_wr_q, ram_wr_d;
    logic                   ram_req_q, ram_req_d;
    logic                   illegal_q, illegal_d;
    logic [NB_CYCLES-1:0]   cycle_q, cycle_d;

    logic [NB_OPCODE-1:0]   opcode;
    logic [NB_OPERAND-1:0]  operand;
    logic [NB_ADDR-1:0]     k_addr;
    logic [NB_DATA-1:0]     k_sext;
    logic [NB_ADDR-1:0]     pc_inc;

    assign opcode  = i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE];
    assign operand = i_rom_data[NB_OPERAND-1:0];
    assign k_addr  = operand[NB_ADDR-1:0];
    assign pc_inc  = pc_q + NB_ADDR'(1);

    // The operand is sign-extended to the data width. When the operand is
    // wider than the data path, it is truncated to its LSBs instead.
    if (NB_OPERAND >= NB_DATA) begin : g_sext_trunc
        assign k_sext = operand[NB_DATA-1:0];
    end else begin : g_sext_ext
        assign k_sext = {{(NB_DATA-NB_OPERAND){operand[NB_OPERAND-1]}}, operand};
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        acc_d      = acc_q;
        op_d       = op_q;
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_wr_d   = ram_wr_q;
        ram_req_d  = ram_req_q;
        illegal_d  = 1'b0;
        cycle_d    = cycle_q;

        // The counter runs in every non-HALT cycle and sticks at all-ones.
        if (state_q != ST_HALT && cycle_q != '1) begin
            cycle_d = cycle_q + NB_CYCLES'(1);
        end

        case (state_q)
            ST_EXEC: begin
                pc_d = pc_inc;
                case (opcode)
                    OP_HLT: begin
                        pc_d    = pc_q;
                        state_d = ST_HALT;
                    end
                    OP_STO: begin
                        pc_d       = pc_q;
                        ram_addr_d = k_addr;
                        ram_data_d = acc_q;
                        ram_wr_d   = 1'b1;
                        ram_req_d  = 1'b1;
                        op_d       = opcode;
                        state_d    = ST_MEM;
                    end
                    OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        pc_d       = pc_q;
                        ram_addr_d = k_addr;
                        ram_wr_d   = 1'b0;
                        ram_req_d  = 1'b1;
                        op_d       = opcode;
                        state_d    = ST_MEM;
                    end
                    OP_LDI:  acc_d = k_sext;
                    OP_ADDI: acc_d = acc_q + k_sext;
                    OP_SUBI: acc_d = acc_q - k_sext;
                    OP_ANDI: acc_d = acc_q & k_sext;
                    OP_JMP:  pc_d  = k_addr;
                    OP_BEQ:  if (acc_q == '0) pc_d = k_addr;
                    OP_BNE:  if (acc_q != '0) pc_d = k_addr;
                    OP_BLT:  if (acc_q[NB_DATA-1]) pc_d = k_addr;
                    OP_NOP: ;
                    default: illegal_d = 1'b1;
                endcase
            end
            ST_MEM: begin
                if (i_ram_ack) begin
                    case (op_q)
                        OP_LD:   acc_d = i_ram_data;
                        OP_ADD:  acc_d = acc_q + i_ram_data;
                        OP_SUB:  acc_d = acc_q - i_ram_data;
                        OP_AND:  acc_d = acc_q & i_ram_data;
                        OP_OR:   acc_d = acc_q | i_ram_data;
                        OP_XOR:  acc_d = acc_q ^ i_ram_data;
                        default: ;
                    endcase
                    ram_req_d = 1'b0;
                    pc_d      = pc_inc;
                    state_d   = ST_EXEC;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_EXEC;
            pc_q       <= '0;
            acc_q      <= '0;
            op_q       <= '0;
            ram_addr_q <= '0;
            ram_data_q <= '0;
            ram_wr_q   <= 1'b0;
            ram_req_q  <= 1'b0;
            illegal_q  <= 1'b0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            ram_addr_q <= ram_addr_d;
            ram_data_q <= ram_data_d;
            ram_wr_q   <= ram_wr_d;
            ram_req_q  <= ram_req_d;
            illegal_q  <= illegal_d;
            cycle_q    <= cycle_d;
        end
    end

    assign o_rom_addr      = pc_q;
    assign o_ram_addr      = ram_addr_q;
    assign o_ram_data      = ram_data_q;
    assign o_ram_wr_enable = ram_wr_q;
    assign o_ram_req       = ram_req_q;
    assign o_acc           = acc_q;
    assign o_program_done  = (state_q == ST_HALT);
    assign o_illegal       = illegal_q;
    assign o_cycle_count   = cycle_q;

endmodule

// File: tb/tb_bip_cpu_hs.sv
// Bench for bip_cpu_hs: directed scenarios plus random programs checked
// against an instruction-level reference model.
module tb_bip_cpu_hs;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_data;
    logic [15:0] ram_rdata = '0;
    logic        ram_ack = 1'b0;
    logic [10:0] o_rom_addr, o_ram_addr;
    logic [15:0] o_ram_data, o_acc;
    logic        o_ram_wr_enable, o_ram_req, o_program_done, o_illegal;
    logic [31:0] o_cycle_count;

    logic [15:0] rom  [0:2047];
    logic [15:0] ram  [0:2047];
    logic [15:0] mram [0:2047];

    int n_cmp = 0;
    int n_err = 0;
    int wait_q[$];
    int illegal_seen = 0;
    bit resp_en = 1'b1;
    bit force_ack = 1'b0;
    bit resp_busy = 1'b0;
    int resp_left = 0;
    logic [10:0] cap_addr;
    logic [15:0] cap_data;
    logic        cap_wr;

    assign rom_data = rom[o_rom_addr];

    bip_cpu_hs dut (
        .i_clock(clk), .i_reset(rst_n), .i_rom_data(rom_data),
        .i_ram_data(ram_rdata), .i_ram_ack(ram_ack),
        .o_rom_addr(o_rom_addr), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
        .o_ram_wr_enable(o_ram_wr_enable), .o_ram_req(o_ram_req), .o_acc(o_acc),
        .o_program_done(o_program_done), .o_illegal(o_illegal), .o_cycle_count(o_cycle_count)
    );

    always #5 clk = ~clk;

    // RAM responder: takes each request's wait count from wait_q, checks that
    // the request stays stable, and performs the access when it acks.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_busy = 1'b0;
            ram_ack   = 1'b0;
        end else if (!resp_en) begin
            ram_ack = force_ack;
        end else begin
            ram_ack = 1'b0;
            if (resp_busy && !o_ram_req) begin
                n_cmp++; n_err++;
                $display("FAIL req_dropped: o_ram_req=0 required 1 before ack");
                resp_busy = 1'b0;
            end else if (resp_busy) begin
                n_cmp++;
                if ({o_ram_addr, o_ram_data, o_ram_wr_enable} !== {cap_addr, cap_data, cap_wr}) begin
                    n_err++;
                    $display("FAIL req_stable: got addr=%h data=%h wr=%b required addr=%h data=%h wr=%b",
                             o_ram_addr, o_ram_data, o_ram_wr_enable, cap_addr, cap_data, cap_wr);
                end
            end else if (o_ram_req) begin
                resp_busy = 1'b1;
                cap_addr  = o_ram_addr;
                cap_data  = o_ram_data;
                cap_wr    = o_ram_wr_enable;
                resp_left = 0;
                if (wait_q.size() > 0) resp_left = wait_q.pop_front();
            end
            if (resp_busy) begin
                if (resp_left == 0) begin
                    ram_ack = 1'b1;
                    if (cap_wr) ram[cap_addr] = cap_data;
                    else ram_rdata = ram[cap_addr];
                    resp_busy = 1'b0;
                end else begin
                    resp_left--;
                end
            end
        end
        if (o_illegal) illegal_seen++;
    end

    function automatic logic [15:0] ins(input int op, input int k);
        logic [4:0]  o5;
        logic [10:0] k11;
        o5  = 5'(op);
        k11 = 11'(k);
        return {o5, k11};
    endfunction

    task automatic hold_reset();
        rst_n = 1'b0;
        #1;
        wait_q.delete();
        for (int i = 0; i < 2048; i++) rom[i] = 16'h0000;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        illegal_seen = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (!o_program_done && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (!o_program_done) begin
            n_err++;
            $display("FAIL %s_timeout: program_done=0 after %0d cycles, required 1", name, budget);
        end
    endtask

    task automatic test_reset();
        hold_reset();
        @(negedge clk);
        n_cmp++; if (o_rom_addr !== 11'd0) begin n_err++; $display("FAIL rst_pc: got %h required 0", o_rom_addr); end
        n_cmp++; if (o_acc !== 16'd0) begin n_err++; $display("FAIL rst_acc: got %h required 0", o_acc); end
        n_cmp++; if ({o_ram_req, o_ram_wr_enable, o_program_done, o_illegal} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b required 0000", {o_ram_req, o_ram_wr_enable, o_program_done, o_illegal}); end
        n_cmp++; if ({o_ram_addr, o_ram_data, o_cycle_count} !== '0) begin n_err++; $display("FAIL rst_regs: got %h/%h/%h required 0", o_ram_addr, o_ram_data, o_cycle_count); end
    endtask

    task automatic test_basic();
        int exp_pc[3] = '{0, 1, 2};
        hold_reset();
        rom[0] = ins(3, 5); rom[1] = ins(5, -3); rom[2] = ins(0, 0);
        release_reset();
        for (int c = 0; c < 3; c++) begin
            n_cmp++; if (o_rom_addr !== 11'(exp_pc[c]) || o_program_done !== 1'b0) begin n_err++; $display("FAIL basic_pc c%0d: got pc=%0d done=%b required pc=%0d done=0", c, o_rom_addr, o_program_done, exp_pc[c]); end
            @(negedge clk);
        end
        n_cmp++; if (o_program_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b required 1", o_program_done); end
        n_cmp++; if (o_acc !== 16'd2) begin n_err++; $display("FAIL basic_acc: got %h required 2", o_acc); end
        n_cmp++; if (o_cycle_count !== 32'd3) begin n_err++; $display("FAIL basic_cycles: got %0d required 3", o_cycle_count); end
        repeat (3) @(negedge clk);
        n_cmp++; if (o_cycle_count !== 32'd3 || o_rom_addr !== 11'd2 || o_acc !== 16'd2) begin n_err++; $display("FAIL halt_frozen: got cyc=%0d pc=%0d acc=%h required 3/2/2", o_cycle_count, o_rom_addr, o_acc); end
    endtask

    task automatic test_sto_wait();
        int req_cycles;
        hold_reset();
        rom[0] = ins(3, 7); rom[1] = ins(1, 10); rom[2] = ins(0, 0);
        ram[10] = 16'hDEAD;
        wait_q.push_back(3);
        release_reset();
        @(negedge clk);
        @(negedge clk);
        req_cycles = 0;
        while (o_ram_req && req_cycles < 20) begin
            req_cycles++;
            n_cmp++; if (o_rom_addr !== 11'd1 || o_ram_addr !== 11'd10 || o_ram_data !== 16'd7 || o_ram_wr_enable !== 1'b1) begin n_err++; $display("FAIL sto_hold: got pc=%0d addr=%0d data=%h wr=%b required 1/10/7/1", o_rom_addr, o_ram_addr, o_ram_data, o_ram_wr_enable); end
            @(negedge clk);
        end
        n_cmp++; if (req_cycles !== 4) begin n_err++; $display("FAIL sto_req_len: got %0d required 4", req_cycles); end
        n_cmp++; if (o_rom_addr !== 11'd2) begin n_err++; $display("FAIL sto_pc_after: got %0d required 2", o_rom_addr); end
        wait_done(10, "sto");
        n_cmp++; if (ram[10] !== 16'd7) begin n_err++; $display("FAIL sto_ram: got %h required 7", ram[10]); end
        n_cmp++; if (o_cycle_count !== 32'd7) begin n_err++; $display("FAIL sto_cycles: got %0d required 7", o_cycle_count); end
    endtask

    task automatic test_ld_add();
        int exp_pc[5] = '{0, 0, 1, 1, 2};
        hold_reset();
        rom[0] = ins(2, 3); rom[1] = ins(4, 4); rom[2] = ins(0, 0);
        ram[3] = 16'h1234; ram[4] = 16'h0001;
        wait_q.push_back(0); wait_q.push_back(0);
        release_reset();
        for (int c = 0; c < 5; c++) begin
            n_cmp++; if (o_rom_addr !== 11'(exp_pc[c])) begin n_err++; $display("FAIL ldadd_pc c%0d: got %0d required %0d", c, o_rom_addr, exp_pc[c]); end
            @(negedge clk);
        end
        n_cmp++; if (o_program_done !== 1'b1 || o_acc !== 16'h1235) begin n_err++; $display("FAIL ldadd_acc: got done=%b acc=%h required 1/1235", o_program_done, o_acc); end
        n_cmp++; if (o_cycle_count !== 32'd5) begin n_err++; $display("FAIL ldadd_cycles: got %0d required 5", o_cycle_count); end
    endtask

    task automatic test_branch_wrap();
        int exp_pc[7] = '{0, 20, 20, 21, 2047, 0, 1};
        hold_reset();
        rom[0] = ins(15, 20); rom[1] = ins(0, 0);
        rom[20] = ins(2, 5); rom[21] = ins(17, 11'h7FF); rom[2047] = ins(31, 0);
        ram[5] = 16'h8000;
        wait_q.push_back(1);
        release_reset();
        for (int c = 0; c < 7; c++) begin
            n_cmp++; if (o_rom_addr !== 11'(exp_pc[c])) begin n_err++; $display("FAIL branch_pc c%0d: got %0d required %0d", c, o_rom_addr, exp_pc[c]); end
            @(negedge clk);
            if (c == 1) @(negedge clk);
        end
        n_cmp++; if (o_program_done !== 1'b1 || o_rom_addr !== 11'd1 || o_acc !== 16'h8000) begin n_err++; $display("FAIL branch_end: got done=%b pc=%0d acc=%h required 1/1/8000", o_program_done, o_rom_addr, o_acc); end
    endtask

    task automatic test_illegal();
        hold_reset();
        rom[0] = ins(3, 3); rom[1] = ins(22, 0); rom[2] = ins(0, 0);
        release_reset();
        @(negedge clk);
        n_cmp++; if (o_illegal !== 1'b0 || o_rom_addr !== 11'd1) begin n_err++; $display("FAIL ill_before: got ill=%b pc=%0d required 0/1", o_illegal, o_rom_addr); end
        @(negedge clk);
        n_cmp++; if (o_illegal !== 1'b1 || o_rom_addr !== 11'd2 || o_acc !== 16'd3) begin n_err++; $display("FAIL ill_pulse: got ill=%b pc=%0d acc=%h required 1/2/3", o_illegal, o_rom_addr, o_acc); end
        @(negedge clk);
        n_cmp++; if (o_illegal !== 1'b0 || o_program_done !== 1'b1) begin n_err++; $display("FAIL ill_after: got ill=%b done=%b required 0/1", o_illegal, o_program_done); end
    endtask

    task automatic test_reset_mid();
        hold_reset();
        resp_en = 1'b0;
        rom[0] = ins(3, 1); rom[1] = ins(1, 6); rom[2] = ins(0, 0);
        release_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (o_ram_req !== 1'b1) begin n_err++; $display("FAIL mid_req_up: got %b required 1", o_ram_req); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (o_ram_req !== 1'b0 || o_rom_addr !== 11'd0 || o_acc !== 16'd0) begin n_err++; $display("FAIL mid_async: got req=%b pc=%0d acc=%h required 0/0/0", o_ram_req, o_rom_addr, o_acc); end
        rom[0] = ins(3, 9); rom[1] = ins(0, 0); rom[2] = ins(0, 0);
        force_ack = 1'b1;
        release_reset();
        n_cmp++; if (o_rom_addr !== 11'd0 || o_acc !== 16'd0) begin n_err++; $display("FAIL mid_release: got pc=%0d acc=%h required 0/0", o_rom_addr, o_acc); end
        @(negedge clk);
        n_cmp++; if (o_rom_addr !== 11'd1 || o_acc !== 16'd9 || o_ram_req !== 1'b0) begin n_err++; $display("FAIL stray_ack: got pc=%0d acc=%h req=%b required 1/9/0", o_rom_addr, o_acc, o_ram_req); end
        @(negedge clk);
        n_cmp++; if (o_program_done !== 1'b1 || o_acc !== 16'd9) begin n_err++; $display("FAIL stray_end: got done=%b acc=%h required 1/9", o_program_done, o_acc); end
        force_ack = 1'b0;
        resp_en = 1'b1;
    endtask

    // Instruction-level reference: walks the program from PC 0 until HLT,
    // charging 1 cycle per instruction plus 1 + waits for each memory access.
    task automatic model_run(input int waits[64], output logic [15:0] acc,
                             output logic [10:0] pc, output int cyc, output int ill);
        logic [15:0] w, m, sk;
        logic [4:0]  op;
        logic [10:0] k;
        int wi;
        acc = 0; pc = 0; cyc = 0; ill = 0; wi = 0;
        for (int step = 0; step < 4000; step++) begin
            w  = rom[pc];
            op = w[15:11];
            k  = w[10:0];
            sk = {{5{k[10]}}, k};
            cyc++;
            if (op == 5'd0) break;
            if (op inside {5'd1, 5'd2, 5'd4, 5'd6, 5'd8, 5'd10, 5'd12}) begin
                cyc += 1 + waits[wi];
                wi++;
                m = mram[k];
                case (op)
                    5'd1:  mram[k] = acc;
                    5'd2:  acc = m;
                    5'd4:  acc = acc + m;
                    5'd6:  acc = acc - m;
                    5'd8:  acc = acc & m;
                    5'd10: acc = acc | m;
                    default: acc = acc ^ m;
                endcase
                pc = pc + 1;
            end else begin
                case (op)
                    5'd3:  begin acc = sk;       pc = pc + 1; end
                    5'd5:  begin acc = acc + sk; pc = pc + 1; end
                    5'd7:  begin acc = acc - sk; pc = pc + 1; end
                    5'd9:  begin acc = acc & sk; pc = pc + 1; end
                    5'd14: pc = k;
                    5'd15: pc = (acc == 0) ? k : pc + 1;
                    5'd16: pc = (acc != 0) ? k : pc + 1;
                    5'd17: pc = acc[15] ? k : pc + 1;
                    5'd31: pc = pc + 1;
                    default: begin ill++; pc = pc + 1; end
                endcase
            end
        end
    endtask

    task automatic test_random(input int t);
        int mem_ops[7] = '{1, 2, 4, 6, 8, 10, 12};
        int imm_ops[4] = '{3, 5, 7, 9};
        int br_ops[4]  = '{14, 15, 16, 17};
        int bad_ops[5] = '{11, 13, 18, 25, 30};
        int waits[64];
        int n, r, exp_cyc, exp_ill;
        logic [15:0] exp_acc;
        logic [10:0] exp_pc;
        hold_reset();
        n = 16 + $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      rom[i] = ins(mem_ops[$urandom_range(0, 6)], $urandom_range(0, 15));
            else if (r < 7) rom[i] = ins(imm_ops[$urandom_range(0, 3)], $urandom_range(0, 2047));
            else if (r < 9) rom[i] = ins(br_ops[$urandom_range(0, 3)], $urandom_range(i + 1, n));
            else            rom[i] = ($urandom_range(0, 1) == 1) ? ins(31, 0) : ins(bad_ops[$urandom_range(0, 4)], $urandom_range(0, 2047));
        end
        rom[n] = ins(0, 0);
        for (int i = 0; i < 16; i++) begin
            ram[i]  = 16'($urandom);
            mram[i] = ram[i];
        end
        for (int i = 0; i < 64; i++) begin
            waits[i] = $urandom_range(0, 3);
            wait_q.push_back(waits[i]);
        end
        model_run(waits, exp_acc, exp_pc, exp_cyc, exp_ill);
        release_reset();
        wait_done(3000, "rand");
        @(negedge clk);
        n_cmp++; if (o_acc !== exp_acc) begin n_err++; $display("FAIL rand%0d_acc: got %h required %h", t, o_acc, exp_acc); end
        n_cmp++; if (o_rom_addr !== exp_pc) begin n_err++; $display("FAIL rand%0d_pc: got %0d required %0d", t, o_rom_addr, exp_pc); end
        n_cmp++; if (o_cycle_count !== 32'(exp_cyc)) begin n_err++; $display("FAIL rand%0d_cycles: got %0d required %0d", t, o_cycle_count, exp_cyc); end
        n_cmp++; if (illegal_seen !== exp_ill) begin n_err++; $display("FAIL rand%0d_illegal: got %0d required %0d", t, illegal_seen, exp_ill); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (ram[i] !== mram[i]) begin n_err++; $display("FAIL rand%0d_ram[%0d]: got %h required %h", t, i, ram[i], mram[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sto_wait();
        test_ld_add();
        test_branch_wrap();
        test_illegal();
        test_reset_mid();
        for (int t = 0; t < 8; t++) test_random(t);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bip_cpu_hs.md
Name: bip_cpu_hs

Overview:
- Parametrised successor of the single-accumulator BIP CPU.
- Executes one instruction per cycle from a combinational-read program ROM.
- Data-RAM accesses use a req/ack handshake with any number of wait states.
- Adds conditional branches, logic ops, an illegal-opcode flag, an accumulator observation port and a saturating cycle counter.
- Sits between program ROM and data RAM in the TP top level and replaces the fixed-timing CPU.

Parameters:
- NB_INSTRUCTION, 16, instruction width.
- NB_OPCODE, 5, opcode field width in instruction MSBs.
- NB_OPERAND, NB_INSTRUCTION-NB_OPCODE, operand field width in LSBs.
- NB_ADDR, 11, ROM and RAM address width; operand[NB_ADDR-1:0] is used as the address.
- NB_DATA, 16, accumulator and RAM data width.
- NB_CYCLES, 32, cycle counter width.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_rom_data  in  NB_INSTRUCTION  instruction at o_rom_addr, valid in the same cycle.
- i_ram_data  in  NB_DATA  RAM read data, valid when i_ram_ack=1.
- i_ram_ack  in  1  RAM completion strobe.
- o_rom_addr  out  NB_ADDR  program counter (PC).
- o_ram_addr  out  NB_ADDR  RAM address, registered.
- o_ram_data  out  NB_DATA  RAM write data, registered.
- o_ram_wr_enable  out  1  1 = write, 0 = read; meaningful only while o_ram_req=1.
- o_ram_req  out  1  RAM request.
- o_acc  out  NB_DATA  accumulator.
- o_program_done  out  1  high in HALT state.
- o_illegal  out  1  one-cycle pulse on an undefined opcode.
- o_cycle_count  out  NB_CYCLES  cycles spent outside HALT; saturates at all-ones.

Behaviour:
- Reset (i_reset=0, asynchronous): all outputs are 0; PC=0, ACC=0, state=EXEC, counter=0.
- Reset asserted mid-handshake drops o_ram_req immediately.
- States: EXEC, MEM, HALT.
- EXEC decodes i_rom_data (opcode=op, operand=k; M = RAM[k]) and acts at the clock edge:
  - 00000 HLT: go to HALT; PC holds.
  - 00001 STO: o_ram_addr<=k, o_ram_data<=ACC, o_ram_wr_enable<=1, o_ram_req<=1; go to MEM.
  - 00010 LD, 00100 ADD, 00110 SUB, 01000 AND, 01010 OR, 01100 XOR: o_ram_addr<=k, o_ram_wr_enable<=0, o_ram_req<=1; latch op; go to MEM.
  - 00011 LDI: ACC<=sext(k).
  - 00101 ADDI: ACC<=ACC+sext(k).
  - 00111 SUBI: ACC<=ACC-sext(k).
  - 01001 ANDI: ACC<=ACC & sext(k).
  - 01110 JMP: PC<=k.
  - 01111 BEQ: PC<=k if ACC==0, else PC+1.
  - 10000 BNE: PC<=k if ACC!=0, else PC+1.
  - 10001 BLT: PC<=k if ACC[NB_DATA-1]=1, else PC+1.
  - 11111 NOP.
  - Any other opcode: treated as NOP and o_illegal pulses for one cycle.
  - Non-memory, non-branch instructions set PC<=PC+1.
- Widths:
  - sext() sign-extends k to NB_DATA, or truncates to the LSBs if NB_OPERAND>NB_DATA.
  - Arithmetic is modulo 2^NB_DATA; there is no carry or overflow flag.
  - PC wraps from 2^NB_ADDR-1 to 0.
- MEM:
  - o_ram_req, o_ram_addr, o_ram_data and o_ram_wr_enable hold stable until i_ram_ack=1 is sampled.
  - An ack sampled in the first MEM cycle is legal, giving a 2-cycle memory instruction with zero wait states.
  - On ack: a read op applies M to ACC (LD: ACC<=M; ADD/SUB/AND/OR/XOR: ACC<=ACC op M); o_ram_req<=0; PC<=PC+1; return to EXEC.
  - i_rom_data is ignored while in MEM.
- i_ram_ack outside MEM is ignored.
- HALT is terminal until reset: o_program_done=1, o_ram_req=0, PC and ACC frozen, counter frozen.
- o_cycle_count increments on every clock edge in EXEC or MEM, saturating at 2^NB_CYCLES-1.

Test Plan:
- Reset + ROM {LDI 5, ADDI -3, HLT} -> PC sequence 0,1,2; o_acc=2; o_program_done=1 from cycle 3; o_cycle_count=3.
- STO 10 with ACC=7, ack delayed 4 cycles -> o_ram_req high 4 cycles with addr=10, data=7, wr=1; PC advances only after ack.
- LD 3 (RAM[3]=0x1234), then ADD 4 (RAM[4]=0x0001), zero-wait ack -> o_acc=0x1235; each memory instruction takes 2 cycles.
- ACC=0, BEQ 20 -> PC=20; ACC=0x8000, BLT 0x7FF -> PC=0x7FF; then NOP -> PC wraps to 0.
- Opcode 10110 -> o_illegal pulses for 1 cycle; ACC unchanged; PC+1.
- i_reset low while o_ram_req=1 -> o_ram_req=0 asynchronously; after release PC=0, ACC=0; a stray ack in EXEC has no effect.
